// File: rtl/muldiv_pkg.sv
// Shared definitions for the sequential multiply/divide unit:
// operation encodings, FSM state encoding and the default operand width.
package muldiv_pkg;

    localparam int N_DEFAULT = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PREP_A = 3'd1,
        ST_PREP_B = 3'd2,
        ST_ITER   = 3'd3,
        ST_FIX_LO = 3'd4,
        ST_FIX_HI = 3'd5,
        ST_DONE   = 3'd6
    } state_e;

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic op_is_div(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_seq_au.sv
// n-bit add/subtract unit. With u=1, neg is the unsigned carry (add) or
// borrow (subtract); with u=0 it is the sign of the true signed result.
module au #(
    parameter int n = 32
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         sub,
    input  logic         u,
    output logic [n-1:0] s,
    output logic         neg,
    output logic         ovf
);

    logic [n-1:0] bx;
    logic [n:0]   sum;
    logic         sovf;

    always_comb begin
        bx   = sub ? ~b : b;
        sum  = {1'b0, a} + {1'b0, bx} + {{n{1'b0}}, sub};
        sovf = (a[n-1] == bx[n-1]) && (sum[n-1] != a[n-1]);
    end

    assign s   = sum[n-1:0];
    assign neg = u ? (sum[n] ^ sub) : (sum[n-1] ^ sovf);
    assign ovf = u ? (sum[n] ^ sub) : sovf;

endmodule

// File: rtl/muldiv_seq.sv
// Sequential MULT/MULTU/DIV/DIVU unit with HI/LO registers; operands are
// converted to magnitudes, processed one bit per cycle, then sign-fixed.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int n = N_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         wr_hi,
    input  logic         wr_lo,
    input  logic [n-1:0] wdata,
    output logic         busy,
    output logic         done,
    output logic         dz,
    output logic [n-1:0] hi,
    output logic [n-1:0] lo
);

    localparam int CW = $clog2(n) + 1;

    state_e         state_q, state_d;
    logic [n-1:0]   a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
    logic [1:0]     op_q, op_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           dz_q, dz_d, a_neg_q, a_neg_d, sign_q, sign_d;
    logic           rem_sign_q, rem_sign_d, borrow_q, borrow_d;

    logic [n-1:0]   au_a, au_b, au_s;
    logic           au_sub, au_neg, au_ovf;
    logic           signed_op, div_op, b_neg, q_ok;
    logic           unused_au_ovf;

    assign signed_op     = op_is_signed(op_q);
    assign div_op        = op_is_div(op_q);
    assign b_neg         = signed_op & b_q[n-1];
    assign q_ok          = hi_q[n-1] | ~au_neg;
    assign unused_au_ovf = au_ovf;

    au #(.n(n)) u_au (
        .a   (au_a),
        .b   (au_b),
        .sub (au_sub),
        .u   (1'b1),
        .s   (au_s),
        .neg (au_neg),
        .ovf (au_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (start) state_d = ST_PREP_A;
            ST_PREP_A: state_d = (div_op && b_q == '0) ? ST_DONE : ST_PREP_B;
            ST_PREP_B: state_d = ST_ITER;
            ST_ITER:   if (cnt_q == CW'(n - 1)) state_d = ST_FIX_LO;
            ST_FIX_LO: state_d = ST_FIX_HI;
            ST_FIX_HI: state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // The single AU is steered per state: negations use 0 - x, the divide
    // step subtracts the divisor from the shifted partial remainder.
    always_comb begin
        busy   = (state_q != ST_IDLE);
        done   = (state_q == ST_DONE);
        au_a   = '0;
        au_b   = '0;
        au_sub = 1'b0;
        unique case (state_q)
            ST_PREP_A: begin au_sub = 1'b1; au_b = a_q; end
            ST_PREP_B: begin au_sub = 1'b1; au_b = b_q; end
            ST_ITER: begin
                if (div_op) begin
                    au_a   = {hi_q[n-2:0], lo_q[n-1]};
                    au_b   = b_q;
                    au_sub = 1'b1;
                end else begin
                    au_a = hi_q;
                    au_b = a_q;
                end
            end
            ST_FIX_LO: begin au_sub = 1'b1; au_b = lo_q; end
            ST_FIX_HI: begin
                au_sub = 1'b1;
                au_b   = hi_q;
                au_a   = (!div_op && borrow_q) ? '1 : '0;
            end
            default: ;
        endcase
    end

    always_comb begin
        a_d        = a_q;
        b_d        = b_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        op_d       = op_q;
        cnt_d      = cnt_q;
        dz_d       = dz_q;
        a_neg_d    = a_neg_q;
        sign_d     = sign_q;
        rem_sign_d = rem_sign_q;
        borrow_d   = borrow_q;
        unique case (state_q)
            ST_IDLE: begin
                if (wr_hi) hi_d = wdata;
                if (wr_lo) lo_d = wdata;
                if (start) begin
                    a_d  = a;
                    b_d  = b;
                    op_d = op;
                    dz_d = 1'b0;
                end
            end
            ST_PREP_A: begin
                a_neg_d = signed_op & a_q[n-1];
                if (signed_op && a_q[n-1]) a_d = au_s;
                if (div_op && b_q == '0) dz_d = 1'b1;
            end
            ST_PREP_B: begin
                sign_d     = a_neg_q ^ b_neg;
                rem_sign_d = a_neg_q;
                cnt_d      = '0;
                hi_d       = '0;
                if (div_op) begin
                    lo_d = a_q;
                    b_d  = b_neg ? au_s : b_q;
                end else begin
                    lo_d = b_neg ? au_s : b_q;
                end
            end
            ST_ITER: begin
                cnt_d = cnt_q + CW'(1);
                // A set top bit of the old remainder means the shifted value
                // exceeds any divisor, so the subtraction always succeeds.
                if (div_op) begin
                    hi_d = q_ok ? au_s : {hi_q[n-2:0], lo_q[n-1]};
                    lo_d = {lo_q[n-2:0], q_ok};
                end else if (lo_q[0]) begin
                    {hi_d, lo_d} = {au_neg, au_s, lo_q[n-1:1]};
                end else begin
                    {hi_d, lo_d} = {1'b0, hi_q, lo_q[n-1:1]};
                end
            end
            ST_FIX_LO: begin
                borrow_d = 1'b0;
                if (sign_q) begin
                    lo_d     = au_s;
                    borrow_d = au_neg;
                end
            end
            ST_FIX_HI: begin
                if (div_op ? rem_sign_q : sign_q) hi_d = au_s;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q        <= '0;
            b_q        <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            op_q       <= '0;
            cnt_q      <= '0;
            dz_q       <= 1'b0;
            a_neg_q    <= 1'b0;
            sign_q     <= 1'b0;
            rem_sign_q <= 1'b0;
            borrow_q   <= 1'b0;
        end else begin
            a_q        <= a_d;
            b_q        <= b_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            op_q       <= op_d;
            cnt_q      <= cnt_d;
            dz_q       <= dz_d;
            a_neg_q    <= a_neg_d;
            sign_q     <= sign_d;
            rem_sign_q <= rem_sign_d;
            borrow_q   <= borrow_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;
    assign dz = dz_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed steps, a reference model
// built on 64-bit arithmetic, and a scoreboard queue of expected results.
module tb_muldiv_seq;

    localparam int N       = 32;
    localparam int LAT_OP  = N + 5;
    localparam int LAT_DZ  = 2;

    typedef struct {
        logic [N-1:0] hi;
        logic [N-1:0] lo;
        logic         dz;
        int           lat;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [1:0]   op;
    logic [N-1:0] a, b;
    logic         wr_hi, wr_lo;
    logic [N-1:0] wdata;
    logic         busy, done, dz;
    logic [N-1:0] hi, lo;

    exp_t         sb[$];
    logic [N-1:0] model_hi, model_lo;
    int           checks = 0;
    int           errors = 0;

    muldiv_seq #(.n(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .wr_hi (wr_hi),
        .wr_lo (wr_lo),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .dz    (dz),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour from plain integer arithmetic on 64-bit values.
    task automatic runModel(input logic [1:0] o, input logic [N-1:0] x, input logic [N-1:0] y,
                            output exp_t e);
        logic [63:0] p, q, r;
        e.dz  = 1'b0;
        e.lat = LAT_OP;
        case (o)
            2'b00: p = 64'($signed(x)) * 64'($signed(y));
            2'b01: p = {32'd0, x} * {32'd0, y};
            2'b10: begin
                if (y != 0) begin
                    q = longint'($signed(x)) / longint'($signed(y));
                    r = longint'($signed(x)) % longint'($signed(y));
                    p = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (y != 0) p = {x % y, x / y};
            end
        endcase
        if (o[1] && y == 0) begin
            e.dz  = 1'b1;
            e.lat = LAT_DZ;
        end else begin
            model_hi = p[63:32];
            model_lo = p[31:0];
        end
        e.hi = model_hi;
        e.lo = model_lo;
    endtask

    task automatic applyStimulus(input logic [1:0] o, input logic [N-1:0] x, input logic [N-1:0] y,
                                 input bit with_wr, input logic [N-1:0] wh, input logic [N-1:0] wl);
        exp_t e;
        if (with_wr) begin
            model_hi = wh;
            model_lo = wl;
        end
        runModel(o, x, y, e);
        sb.push_back(e);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        wr_hi = with_wr; wr_lo = with_wr;
        wdata = wh;
        if (with_wr) begin
            // wdata is shared, so both strobes load the same value.
            model_hi = wh; model_lo = wh;
            if (e.dz) begin
                sb[$].hi = wh; sb[$].lo = wh;
            end
        end
        @(posedge clk);
        #1;
        start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input int inject_at);
        exp_t e;
        int   lat;
        int   extra;
        bit   seen;
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (inject_at > 0 && lat == inject_at) begin
                start = 1'b1; op = 2'b10; a = 32'h0000_0064; b = 32'h0000_0003;
                wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'hDEAD_BEEF;
            end else if (inject_at > 0 && lat == inject_at + 1) begin
                start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
            end
            if (done === 1'b1) seen = 1'b1;
        end
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
        if (sb.size() == 0) begin
            check({tag, "_scoreboard"}, 64'd0, 64'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_hi"}, 64'(hi), 64'(e.hi));
            check({tag, "_lo"}, 64'(lo), 64'(e.lo));
            check({tag, "_dz"}, 64'(dz), 64'(e.dz));
            check({tag, "_latency"}, 64'(lat), 64'(e.lat));
        end
        extra = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        check({tag, "_single_done"}, 64'(extra), 64'd0);
        check({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int nodone;
        logic [N-1:0] ra, rb;
        logic [1:0]   ro;

        rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
        wr_hi = 1'b0; wr_lo = 1'b0; wdata = '0;
        model_hi = '0; model_lo = '0;
        repeat (2) @(negedge clk);
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_dz", 64'(dz), 64'd0);
        rst_n = 1'b1;

        // MTHI / MTLO while idle
        @(negedge clk);
        wr_hi = 1'b1; wdata = 32'h0000_0011;
        @(negedge clk);
        wr_hi = 1'b0; wr_lo = 1'b1; wdata = 32'h0000_0022;
        @(negedge clk);
        wr_lo = 1'b0;
        model_hi = 32'h11; model_lo = 32'h22;
        check("mthi", 64'(hi), 64'h11);
        check("mtlo", 64'(lo), 64'h22);

        applyStimulus(2'b00, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, '0, '0);
        checkOutput("mult_m1x2", 0);
        applyStimulus(2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, '0, '0);
        checkOutput("multu_ffx2", 0);
        applyStimulus(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, '0, '0);
        checkOutput("div_m7d2", 0);
        applyStimulus(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, '0, '0);
        checkOutput("div_wrap", 0);

        // Divide by zero leaves the previously written HI/LO untouched
        @(negedge clk);
        wr_hi = 1'b1; wdata = 32'h11;
        @(negedge clk);
        wr_hi = 1'b0; wr_lo = 1'b1; wdata = 32'h22;
        @(negedge clk);
        wr_lo = 1'b0;
        model_hi = 32'h11; model_lo = 32'h22;
        applyStimulus(2'b11, 32'h0000_0007, 32'h0000_0000, 1'b0, '0, '0);
        checkOutput("divu_by0", 0);
        applyStimulus(2'b10, 32'h0000_0005, 32'h0000_0000, 1'b0, '0, '0);
        checkOutput("div_by0", 0);

        // Start and MTHI/MTLO pulsed mid-operation must be ignored
        applyStimulus(2'b01, 32'h0000_0003, 32'h0000_0005, 1'b0, '0, '0);
        checkOutput("multu_busy_ignore", 10);

        // Writes and start in the same edge: operation result wins
        applyStimulus(2'b01, 32'h0000_0006, 32'h0000_0007, 1'b1, 32'hABCD_0000, 32'hABCD_0000);
        checkOutput("wr_with_start", 0);

        for (int i = 0; i < 6; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            if (i == 5) rb = 32'hFFFF_FFFF;
            applyStimulus(ro, ra, rb, 1'b0, '0, '0);
            checkOutput($sformatf("rand%0d_op%0d", i, ro), 0);
        end

        // Reset in the middle of a DIVU aborts it without a done pulse
        @(negedge clk);
        start = 1'b1; op = 2'b11; a = 32'd1000; b = 32'd3;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (19) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_hi", 64'(hi), 64'd0);
        check("midrst_lo", 64'(lo), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_dz", 64'(dz), 64'd0);
        nodone = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done === 1'b1) nodone++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) nodone++;
        end
        check("midrst_no_done", 64'(nodone), 64'd0);
        model_hi = '0; model_lo = '0;
        applyStimulus(2'b11, 32'd100, 32'd7, 1'b0, '0, '0);
        checkOutput("divu_after_rst", 0);

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have parameter n, default 32, the operand/HI/LO width.
REQ-002 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port start, input, 1: request a new operation; sampled only in IDLE.
REQ-005 SHALL have port op, input, 2: operation select; 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have port a, input, n: multiplicand or dividend, captured with start.
REQ-007 SHALL have port b, input, n: multiplier or divisor, captured with start.
REQ-008 SHALL have port wr_hi, input, 1: MTHI strobe; honoured only when busy=0.
REQ-009 SHALL have port wr_lo, input, 1: MTLO strobe; honoured only when busy=0.
REQ-010 SHALL have port wdata, input, n: MTHI/MTLO data.
REQ-011 SHALL have port busy, output, 1: high from the cycle after start is accepted until DONE inclusive.
REQ-012 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-013 SHALL have port dz, output, 1: divide-by-zero flag of the last operation; held until the next accepted start.
REQ-014 SHALL have port hi, output, n: HI register (high product word or remainder).
REQ-015 SHALL have port lo, output, n: LO register (low product word or quotient).

Function
REQ-016 SHALL use an FSM with states IDLE, PREP_A, PREP_B, ITER, FIX_LO, FIX_HI and DONE.
REQ-017 In IDLE with start=1, SHALL latch a, b and op, clear dz, and enter PREP_A.
REQ-018 PREP_A SHALL replace operand A by its magnitude via the shared AU when the op is signed (00 or 10) and a[n-1]=1; otherwise A passes through unchanged.
REQ-019 PREP_B SHALL do the same for operand B, and SHALL record the result-sign bits: product/quotient sign = a[n-1]^b[n-1]; remainder sign = a[n-1] (both only for signed ops).
REQ-020 For a divide with b==0, PREP_A SHALL set dz=1 and go directly to DONE, leaving hi/lo unchanged; done is therefore asserted 2 cycles after the start edge.
REQ-021 ITER SHALL run exactly n cycles, tracked by a log2(n)+1-bit counter.
REQ-022 For multiply, each ITER cycle SHALL perform one shift-add step on the 2n-bit {hi,lo} accumulator, using AU add with u=1.
REQ-023 For divide, each ITER cycle SHALL perform one restoring step: AU subtract with u=1; the partial remainder is kept when neg=0 and restored when neg=1; the quotient bit = ~neg.
REQ-024 FIX_LO SHALL conditionally negate lo (0 - lo via AU, sub=1) and save the borrow.
REQ-025 FIX_HI SHALL conditionally negate hi, propagating the FIX_LO borrow for a product; for a divide it SHALL negate hi (remainder) and lo (quotient) independently per their own sign bits.
REQ-026 Latency SHALL be fixed at n+5 cycles from the start-sampling edge to done for all non-dz ops (37 for n=32); signed and unsigned ops take identical time.
REQ-027 DONE SHALL assert done=1 for exactly one cycle, with hi/lo final in that same cycle, then return to IDLE.
REQ-028 start while busy=1 SHALL be ignored, with no queuing.
REQ-029 wr_hi/wr_lo while busy=1 SHALL be ignored.
REQ-030 In IDLE, wr_hi/wr_lo SHALL load wdata on the next edge; when both are asserted with start, the writes are applied and start is accepted in the same edge; the operation later overwrites hi/lo.
REQ-031 AU overflow (ovf) SHALL be ignored; signed DIV of 0x80000000 by -1 SHALL wrap, giving lo=0x80000000 and hi=0.
REQ-032 The AU SHALL be driven with a=0, b=0, sub=0 in IDLE and DONE.

Reset
REQ-033 SHALL, on rst_n=0 and independent of clk, force state=IDLE, hi=0, lo=0, busy=0, done=0, dz=0 and counter=0.
REQ-034 Reset asserted mid-operation SHALL abort the operation with no done pulse; the first start after rst_n rises SHALL be accepted normally.

Structure
REQ-035 SHALL take the op encodings, FSM state encoding and default n from the shared package muldiv_pkg.
REQ-036 SHALL instantiate exactly one sub-module: the existing n-bit arithmetic unit au (inputs a, b, sub, u; outputs s, neg, ovf), time-multiplexed across all states.

Verification
REQ-037 MULT a=0xFFFFFFFF, b=0x00000002 -> done at cycle 37, hi=0xFFFFFFFF, lo=0xFFFFFFFE, dz=0.
REQ-038 MULTU same operands -> hi=0x00000001, lo=0xFFFFFFFE, latency 37.
REQ-039 DIV a=0xFFFFFFF9 (-7), b=0x00000002 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); then DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-040 DIVU a=7, b=0 with prior hi=0x11, lo=0x22 -> done 2 cycles after start, dz=1, hi=0x11, lo=0x22.
REQ-041 Second start and wr_hi pulsed at cycle 10 of a MULTU 3*5 -> both ignored; hi=0, lo=15 at cycle 37; exactly one done.
REQ-042 rst_n low at cycle 20 of a DIVU -> all outputs 0 immediately and no done; a new DIVU 100/7 -> lo=14, hi=2.
